// File: rtl/pcl_3w_slave_pkg.sv
// pcl_3w_slave_pkg: shared widths, command encoding and FSM state type for the 3W slave
package pcl_3w_slave_pkg;

    localparam int   THREEWIRE_MAX_ADDRESS_BITS = 8;
    localparam int   THREEWIRE_MAX_DATA_BITS    = 16;
    localparam logic THREEWIRE_CMD_READ         = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RFETCH,
        ST_RDATA,
        ST_DONE
    } tw_state_t;

    // Sized so the counter can hold the largest field length without wrapping.
    function automatic int bit_cnt_width(input int a_bits, input int d_bits);
        return $clog2((a_bits > d_bits ? a_bits : d_bits) + 1);
    endfunction

endpackage

// File: rtl/pcl_3w_slave_input_sync.sv
// tw_input_sync: 2-FF synchroniser with rise/fall detection on the synchronised copy
module tw_input_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else        sr <= {sr[1:0], d};

    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/pcl_3w_slave.sv
// pcl_3w_slave: oversampling 3W responder turning R/W+address+data frames into register-bus strobes
module pcl_3w_slave
    import pcl_3w_slave_pkg::*;
#(
    parameter int PCL_3WS_ADDRESS_BITS = THREEWIRE_MAX_ADDRESS_BITS,
    parameter int PCL_3WS_DATA_BITS    = THREEWIRE_MAX_DATA_BITS
) (
    input  logic                            in_clk,
    input  logic                            in_reset_n,
    input  logic                            in_tw_clock,
    input  logic                            in_tw_cs_n,
    inout  wire                             io_tw_data,
    output logic                            out_tw_dir,
    output logic [PCL_3WS_ADDRESS_BITS-1:0] out_reg_addr,
    output logic [PCL_3WS_DATA_BITS-1:0]    out_reg_wdata,
    output logic                            out_reg_wr,
    output logic                            out_reg_rd,
    input  logic [PCL_3WS_DATA_BITS-1:0]    in_reg_rdata,
    output logic                            out_busy,
    output logic                            out_frame_err
);

    localparam int A  = PCL_3WS_ADDRESS_BITS;
    localparam int D  = PCL_3WS_DATA_BITS;
    localparam int CW = bit_cnt_width(A, D);

    tw_state_t       state;
    logic [CW-1:0]   cnt;
    logic            rw;
    logic            fetch_ph;
    logic [D-2:0]    rx_sr;
    logic [D-1:0]    rx_next;
    logic [D-1:0]    tx_sr;
    logic            tx_bit;
    logic            clk_lvl, clk_rise, clk_fall;
    logic            cs_lvl, cs_rise, cs_fall;
    logic            dat_lvl, dat_rise, dat_fall;
    logic            edge_rise, edge_fall;
    logic            unused_sync;

    tw_input_sync u_sync_clk (.clk(in_clk), .rst_n(in_reset_n), .d(in_tw_clock),
                              .level(clk_lvl), .rise(clk_rise), .fall(clk_fall));
    tw_input_sync u_sync_cs  (.clk(in_clk), .rst_n(in_reset_n), .d(in_tw_cs_n),
                              .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    tw_input_sync u_sync_dat (.clk(in_clk), .rst_n(in_reset_n), .d(io_tw_data),
                              .level(dat_lvl), .rise(dat_rise), .fall(dat_fall));

    assign unused_sync = &{clk_lvl, dat_rise, dat_fall};

    // Clock edges only count while the slave is selected.
    assign edge_rise  = clk_rise & ~cs_lvl;
    assign edge_fall  = clk_fall & ~cs_lvl;
    assign rx_next    = {rx_sr, dat_lvl};
    assign io_tw_data = out_tw_dir ? tx_bit : 1'bz;

    always_ff @(posedge in_clk or negedge in_reset_n)
        if (!in_reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rw            <= 1'b0;
            fetch_ph      <= 1'b0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            tx_bit        <= 1'b0;
            out_tw_dir    <= 1'b0;
            out_reg_addr  <= '0;
            out_reg_wdata <= '0;
            out_reg_wr    <= 1'b0;
            out_reg_rd    <= 1'b0;
            out_busy      <= 1'b0;
            out_frame_err <= 1'b0;
        end else begin
            out_reg_wr    <= 1'b0;
            out_reg_rd    <= 1'b0;
            out_frame_err <= 1'b0;
            // Deselect mid-frame wins over any clock edge seen in the same cycle.
            if (cs_rise && state != ST_IDLE && state != ST_DONE) begin
                state         <= ST_IDLE;
                out_frame_err <= 1'b1;
                out_tw_dir    <= 1'b0;
                out_busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE:
                        if (cs_fall) begin
                            state    <= ST_CMD;
                            out_busy <= 1'b1;
                        end
                    ST_CMD:
                        if (edge_rise) begin
                            rw    <= dat_lvl;
                            cnt   <= '0;
                            state <= ST_ADDR;
                        end
                    ST_ADDR:
                        if (edge_rise) begin
                            out_reg_addr <= {out_reg_addr[A-2:0], dat_lvl};
                            if (cnt == CW'(A - 1)) begin
                                cnt        <= '0;
                                fetch_ph   <= 1'b0;
                                out_reg_rd <= rw == THREEWIRE_CMD_READ;
                                state      <= rw == THREEWIRE_CMD_READ ? ST_RFETCH : ST_WDATA;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    ST_WDATA:
                        if (edge_rise) begin
                            rx_sr <= rx_next[D-2:0];
                            if (cnt == CW'(D - 1)) begin
                                out_reg_wdata <= rx_next;
                                out_reg_wr    <= 1'b1;
                                state         <= ST_DONE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    ST_RFETCH: begin
                        // Read data is valid the cycle after the strobe.
                        fetch_ph <= 1'b1;
                        if (fetch_ph) begin
                            tx_sr <= in_reg_rdata;
                            state <= ST_RDATA;
                        end
                    end
                    ST_RDATA:
                        if (edge_fall) begin
                            out_tw_dir <= 1'b1;
                            tx_bit     <= tx_sr[D-1];
                            tx_sr      <= {tx_sr[D-2:0], 1'b0};
                        end else if (edge_rise && out_tw_dir) begin
                            if (cnt == CW'(D - 1)) begin
                                out_tw_dir <= 1'b0;
                                state      <= ST_DONE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    ST_DONE:
                        if (cs_rise) begin
                            state    <= ST_IDLE;
                            out_busy <= 1'b0;
                        end
                    default: state <= ST_IDLE;
                endcase
            end
        end

endmodule

// File: tb/tb_pcl_3w_slave.sv
// tb_pcl_3w_slave: directed 3W master driving the slave; register strobes checked against an expected-event queue
module tb_pcl_3w_slave;

    localparam int HALF = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tw_clock = 1'b0;
    logic        cs_n = 1'b1;
    logic        m_oe = 1'b0;
    logic        m_d = 1'b0;
    wire         tw_data;
    logic        dir, wr, rd, busy, err;
    logic [7:0]  addr;
    logic [15:0] wdata, rdata, rd_val, got;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  a;
        logic [15:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    assign tw_data = m_oe ? m_d : 1'bz;
    always #5 clk = ~clk;

    pcl_3w_slave dut (
        .in_clk(clk),
        .in_reset_n(rst_n),
        .in_tw_clock(tw_clock),
        .in_tw_cs_n(cs_n),
        .io_tw_data(tw_data),
        .out_tw_dir(dir),
        .out_reg_addr(addr),
        .out_reg_wdata(wdata),
        .out_reg_wr(wr),
        .out_reg_rd(rd),
        .in_reg_rdata(rdata),
        .out_busy(busy),
        .out_frame_err(err)
    );

    // Register file answers only on the cycle after a read strobe.
    always @(posedge clk) rdata <= rd ? rd_val : 16'h0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endfunction

    // Monitor: every strobe must match the next expected event (1=wr, 2=rd, 3=err).
    always @(negedge clk)
        if (rst_n && (wr || rd || err)) begin
            ev_t e;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got wr=%0b rd=%0b err=%0b addr=%h required none", wr, rd, err, addr);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", err ? 3 : wr ? 1 : 2, 32'(e.kind));
                if (!err) chk("strobe_addr", 32'(addr), 32'(e.a));
                if (wr)   chk("strobe_wdata", 32'(wdata), 32'(e.d));
            end
        end

    task automatic frame(input logic rw, input logic [7:0] a, input logic [15:0] wd,
                         input int nbits, input int extra, input bit rst_mid,
                         output logic [15:0] rx);
        logic [24:0] bits;
        int bad;
        bits = {rw, a, wd};
        bad  = 0;
        rx   = '0;
        m_oe = 1'b1;
        cs_n = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            tw_clock = 1'b0;
            if (rw && i >= 9) m_oe = 1'b0;
            else              m_d = bits[24-i];
            #HALF;
            if (i == 0) chk("busy_in_frame", 32'(busy), 1);
            if (dir !== (rw && i >= 9)) bad++;
            tw_clock = 1'b1;
            if (rw && i >= 9) rx = {rx[14:0], tw_data};
            #HALF;
        end
        if (rst_mid) begin
            tw_clock = 1'b0;
            #50;
            chk("dir_before_reset", 32'(dir), 1);
            #3 rst_n = 1'b0;
            #1;
            chk("dir_on_reset", 32'(dir), 0);
            chk("busy_on_reset", 32'(busy), 0);
            chk("dir_profile_rst", bad, 0);
            cs_n = 1'b1;
            #96;
        end else begin
            repeat (extra) begin
                tw_clock = 1'b0;
                #HALF;
                tw_clock = 1'b1;
                #HALF;
            end
            tw_clock = 1'b0;
            #HALF;
            chk("dir_released", 32'(dir), 0);
            chk("dir_profile", bad, 0);
            cs_n = 1'b1;
            #(2*HALF);
        end
    endtask

    initial begin
        rd_val = 16'h0;
        repeat (4) @(negedge clk);
        chk("rst_dir",   32'(dir), 0);
        chk("rst_wr",    32'(wr), 0);
        chk("rst_rd",    32'(rd), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_err",   32'(err), 0);
        chk("rst_addr",  32'(addr), 0);
        chk("rst_wdata", 32'(wdata), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        exp_q.push_back('{2'd1, 8'h5A, 16'hBEEF});
        frame(1'b0, 8'h5A, 16'hBEEF, 25, 0, 1'b0, got);
        chk("wr_addr", 32'(addr), 32'h5A);
        chk("wr_data", 32'(wdata), 32'hBEEF);
        chk("busy_after_wr", 32'(busy), 0);

        rd_val = 16'hC3A5;
        exp_q.push_back('{2'd2, 8'h21, 16'h0});
        frame(1'b1, 8'h21, 16'h0, 25, 0, 1'b0, got);
        chk("read_data", 32'(got), 32'hC3A5);

        exp_q.push_back('{2'd3, 8'h0, 16'h0});
        frame(1'b0, 8'h77, 16'hFFFF, 6, 0, 1'b0, got);
        chk("abort_dir", 32'(dir), 0);
        chk("abort_wdata_held", 32'(wdata), 32'hBEEF);
        chk("abort_busy", 32'(busy), 0);

        exp_q.push_back('{2'd1, 8'h10, 16'h0001});
        frame(1'b0, 8'h10, 16'h0001, 25, 0, 1'b0, got);
        chk("post_abort_wdata", 32'(wdata), 32'h0001);

        exp_q.push_back('{2'd1, 8'h33, 16'h1234});
        frame(1'b0, 8'h33, 16'h1234, 25, 4, 1'b0, got);
        chk("extra_addr", 32'(addr), 32'h33);
        chk("extra_wdata", 32'(wdata), 32'h1234);

        rd_val = 16'hA55A;
        exp_q.push_back('{2'd2, 8'h44, 16'h0});
        frame(1'b1, 8'h44, 16'h0, 14, 0, 1'b1, got);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_dir", 32'(dir), 0);
        chk("post_rst_addr", 32'(addr), 0);

        exp_q.push_back('{2'd1, 8'h6C, 16'hF00D});
        frame(1'b0, 8'h6C, 16'hF00D, 25, 0, 1'b0, got);
        rd_val = 16'h9E37;
        exp_q.push_back('{2'd2, 8'h6C, 16'h0});
        frame(1'b1, 8'h6C, 16'h0, 25, 0, 1'b0, got);
        chk("b2b_read_data", 32'(got), 32'h9E37);
        chk("b2b_wdata", 32'(wdata), 32'hF00D);

        repeat (20) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
